// File: rtl/rate_sel_fifo_pkg.sv
// Shared encodings for the rate-selected FIFO / bypass buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rate_sel_fifo_pkg;

   typedef enum logic [1:0] {
      S_FIFO  = 2'b00,
      S_DRAIN = 2'b01,
      S_BYP   = 2'b10
   } state_t;

   localparam logic MODE_FIFO = 1'b0;
   localparam logic MODE_BYP  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, 2**ADD_WIDTH entries, head word presented combinationally.
// Latency: a written word is visible at the head on the cycle after the write.
// Backpressure: writes ignored when full, reads ignored when empty.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADD_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADD_WIDTH:0]    count
);

   localparam int DEPTH = 2**ADD_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADD_WIDTH:0]    wp;
   logic [ADD_WIDTH:0]    rp;
   logic                  wr_go;
   logic                  rd_go;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign full    = (wp[ADD_WIDTH] != rp[ADD_WIDTH]) &&
                    (wp[ADD_WIDTH-1:0] == rp[ADD_WIDTH-1:0]);
   assign empty   = (wp == rp);
   assign count   = wp - rp;
   assign rd_data = mem[rp[ADD_WIDTH-1:0]];
   assign wr_go   = wr && !full;
   assign rd_go   = rd && !empty;

   // Pointer update; reset discards all stored words.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_go) wp <= wp + 1'b1;
         if (rd_go) rp <= rp + 1'b1;
      end
   end

   // Storage array, no reset needed since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (wr_go) mem[wp[ADD_WIDTH-1:0]] <= wr_data;
   end

endmodule

// File: rtl/rate_sel_fifo.sv
// Buffers a stream in a FIFO, or bypasses it when the consumer tick rate beats the producer's.
// Latency: dout one cycle after an accepted read (FIFO) or write (bypass); mode decided one cycle after window end.
// Backpressure: full refuses writes; while draining for bypass full is forced so the FIFO can empty in order.
module rate_sel_fifo
   import rate_sel_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADD_WIDTH  = 3,
   parameter int WIN_LEN    = 64,
   parameter int CNT_WIDTH  = 8,
   parameter int HYST       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wen,
   input  logic                  ren,
   input  logic                  wtick,
   input  logic                  rtick,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADD_WIDTH:0]    count,
   output logic                  lh,
   output logic [CNT_WIDTH-1:0]  freq_w,
   output logic [CNT_WIDTH-1:0]  freq_r
);

   localparam int                   WIN_W    = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
   localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH:0]   HYST_W   = (CNT_WIDTH + 1)'(HYST);

   state_t                 state;
   logic [WIN_W-1:0]       win_cnt;
   logic [CNT_WIDTH-1:0]   wcnt;
   logic [CNT_WIDTH-1:0]   rcnt;
   logic [CNT_WIDTH-1:0]   wcnt_inc;
   logic [CNT_WIDTH-1:0]   rcnt_inc;
   logic                   eval_pend;
   logic                   win_end;
   logic                   want_byp;
   logic                   want_fifo;
   logic                   byp;
   logic                   wr_acc;
   logic                   rd_acc;
   logic [DATA_WIDTH-1:0]  f_head;
   logic                   f_full;
   logic                   f_empty;
   logic [ADD_WIDTH:0]     f_count;

   assign win_end  = (win_cnt == WIN_LAST);
   assign wcnt_inc = (wtick && wcnt != CNT_MAX) ? wcnt + 1'b1 : wcnt;
   assign rcnt_inc = (rtick && rcnt != CNT_MAX) ? rcnt + 1'b1 : rcnt;

   // One extra bit on the compare so freq_w + HYST cannot wrap.
   assign want_byp  = eval_pend && ({1'b0, freq_r} >= ({1'b0, freq_w} + HYST_W));
   assign want_fifo = eval_pend && (freq_w > freq_r);

   assign byp    = (state == S_BYP);
   assign wr_acc = wen && !full && !byp;
   assign rd_acc = ren && !f_empty && !byp;

   // Status seen by the producer/consumer depends on mode.
   always_comb begin
      full  = f_full;
      empty = f_empty;
      count = f_count;
      case (state)
         S_DRAIN: full = 1'b1;
         S_BYP: begin
            full  = 1'b0;
            empty = 1'b1;
            count = '0;
         end
         default: ;
      endcase
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADD_WIDTH  (ADD_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_acc),
      .wr_data (din),
      .rd      (rd_acc),
      .rd_data (f_head),
      .full    (f_full),
      .empty   (f_empty),
      .count   (f_count)
   );

   // Rate window: count ticks, latch totals at window end, flag evaluation next cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         win_cnt   <= '0;
         wcnt      <= '0;
         rcnt      <= '0;
         freq_w    <= '0;
         freq_r    <= '0;
         eval_pend <= 1'b0;
      end else begin
         eval_pend <= win_end;
         if (win_end) begin
            win_cnt <= '0;
            freq_w  <= wcnt_inc;
            freq_r  <= rcnt_inc;
            wcnt    <= CNT_WIDTH'(wtick);
            rcnt    <= CNT_WIDTH'(rtick);
         end else begin
            win_cnt <= win_cnt + 1'b1;
            wcnt    <= wcnt_inc;
            rcnt    <= rcnt_inc;
         end
      end
   end

   // Output register: bypass forwards din, FIFO mode presents the popped head.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (byp && wen) begin
         dout       <= din;
         dout_valid <= 1'b1;
      end else if (rd_acc) begin
         dout       <= f_head;
         dout_valid <= 1'b1;
      end else begin
         dout_valid <= 1'b0;
      end
   end

   // Mode FSM; bypass is entered only with an empty FIFO and no write landing in it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_FIFO;
         lh    <= MODE_FIFO;
      end else begin
         case (state)
            S_FIFO: begin
               if (want_byp) begin
                  if (f_empty && !wr_acc) begin
                     state <= S_BYP;
                     lh    <= MODE_BYP;
                  end else begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (want_fifo) begin
                  state <= S_FIFO;
               end else if (f_empty) begin
                  state <= S_BYP;
                  lh    <= MODE_BYP;
               end
            end
            S_BYP: begin
               if (want_fifo) begin
                  state <= S_FIFO;
                  lh    <= MODE_FIFO;
               end
            end
            default: begin
               state <= S_FIFO;
               lh    <= MODE_FIFO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rate_sel_fifo.sv
// Directed bench for rate_sel_fifo with hand-computed expectations.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked at that point.
// Backpressure: exercised through full/drain refusal cases.
module tb_rate_sel_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din = '0;
   logic       wen = 1'b0;
   logic       ren = 1'b0;
   logic       wtick = 1'b0;
   logic       rtick = 1'b0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       lh;
   logic [7:0] freq_w;
   logic [7:0] freq_r;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   rate_sel_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .wen        (wen),
      .ren        (ren),
      .wtick      (wtick),
      .rtick      (rtick),
      .dout       (dout),
      .dout_valid (dout_valid),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .lh         (lh),
      .freq_w     (freq_w),
      .freq_r     (freq_r)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Edge index 0 after release is window cycle 0.
   task automatic do_reset();
      rst = 1'b0; wen = 1'b0; ren = 1'b0; wtick = 1'b0; rtick = 1'b0;
      step();
      step();
      rst = 1'b1;
      cyc = 0;
   endtask

   // Align to a window start, then drive one full window of ticks and optional writes.
   task automatic run_window(input int pw, input int nw, input int pr, input int nr,
                             input int nwr, input logic [7:0] base);
      while (cyc % 64 != 0) step();
      for (int k = 0; k < 64; k++) begin
         wtick = ((k % pw) == 0) && ((k / pw) < nw);
         rtick = ((k % pr) == 0) && ((k / pr) < nr);
         wen   = (k < nwr);
         din   = 8'(base * (k + 1));
         step();
      end
      wtick = 1'b0; rtick = 1'b0; wen = 1'b0;
   endtask

   initial begin
      // 1: reset values
      do_reset();
      chk("rst_dout", dout, 0);
      chk("rst_dv", dout_valid, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_lh", lh, 0);
      chk("rst_freq_w", freq_w, 0);
      chk("rst_freq_r", freq_r, 0);

      // 2: fill, overflow drop, drain in order
      for (int i = 1; i <= 8; i++) begin
         wen = 1'b1; din = 8'(i);
         step();
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 8);
      din = 8'hFF;
      step();
      wen = 1'b0;
      chk("ovf_count", count, 8);
      for (int i = 1; i <= 8; i++) begin
         ren = 1'b1;
         step();
         chk("rd_dout", dout, 32'(i));
         chk("rd_dv", dout_valid, 1);
      end
      ren = 1'b0;
      step();
      chk("drained_empty", empty, 1);
      chk("drained_dv", dout_valid, 0);

      // 3: fast consumer with empty FIFO goes straight to bypass
      do_reset();
      run_window(4, 16, 2, 32, 0, 8'h00);
      chk("t3_freq_w", freq_w, 16);
      chk("t3_freq_r", freq_r, 32);
      chk("t3_lh_pre", lh, 0);
      step();
      chk("t3_lh", lh, 1);
      chk("t3_empty", empty, 1);
      wen = 1'b1; din = 8'hA5;
      step();
      wen = 1'b0;
      chk("t3_byp_dout", dout, 8'hA5);
      chk("t3_byp_dv", dout_valid, 1);
      chk("t3_byp_count", count, 0);
      step();
      chk("t3_dv_pulse", dout_valid, 0);

      // 4: queued words drain in order before bypass
      do_reset();
      run_window(4, 16, 2, 32, 3, 8'h11);
      chk("t4_count", count, 3);
      step();
      chk("t4_drain_full", full, 1);
      chk("t4_drain_lh", lh, 0);
      wen = 1'b1; din = 8'h77;
      step();
      wen = 1'b0;
      chk("t4_refused", count, 3);
      for (int i = 1; i <= 3; i++) begin
         ren = 1'b1;
         step();
         chk("t4_rd_dout", dout, 32'(8'h11 * i));
      end
      ren = 1'b0;
      chk("t4_empty", empty, 1);
      chk("t4_lh_wait", lh, 0);
      step();
      chk("t4_lh_byp", lh, 1);

      // 5: swap rates back to FIFO, then hysteresis boundary
      run_window(2, 32, 4, 16, 0, 8'h00);
      chk("t5_freq_w", freq_w, 32);
      chk("t5_freq_r", freq_r, 16);
      step();
      chk("t5_lh_fifo", lh, 0);
      chk("t5_count", count, 0);
      chk("t5_empty", empty, 1);
      wen = 1'b1; din = 8'h5A;
      step();
      wen = 1'b0;
      chk("t5_fifo_count", count, 1);
      chk("t5_fifo_dv", dout_valid, 0);
      ren = 1'b1;
      step();
      ren = 1'b0;
      chk("t5_fifo_dout", dout, 8'h5A);
      chk("t5_fifo_rdv", dout_valid, 1);
      run_window(1, 10, 1, 11, 0, 8'h00);
      chk("t5_freq_r11", freq_r, 11);
      step();
      chk("t5_hold_fifo", lh, 0);
      run_window(1, 10, 1, 12, 0, 8'h00);
      step();
      chk("t5_byp_at_hyst", lh, 1);
      run_window(1, 10, 1, 11, 0, 8'h00);
      step();
      chk("t5_hold_byp", lh, 1);

      // 6: reset while draining
      do_reset();
      run_window(4, 16, 2, 32, 2, 8'h31);
      step();
      chk("t6_drain_count", count, 2);
      chk("t6_drain_full", full, 1);
      rst = 1'b0;
      step();
      chk("t6_count", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_lh", lh, 0);
      chk("t6_full", full, 0);
      chk("t6_freq_w", freq_w, 0);
      chk("t6_dout", dout, 0);
      rst = 1'b1;
      wen = 1'b1; din = 8'hC3;
      step();
      wen = 1'b0;
      chk("t6_wr_count", count, 1);
      ren = 1'b1;
      step();
      ren = 1'b0;
      chk("t6_rd_dout", dout, 8'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
